dmem_line_responder: RTL

DMEM_LINE_RESPONDER -- requirements
Module: dmem_line_responder

---
 rtl/dmem_line_responder_pkg.sv | 18 +
 rtl/dmem_line_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dmem_line_responder_pkg.sv
// Shared cache defines: line geometry and the line responder state encoding.
// The WAIT state exists only when DMEM_RESP_WAIT_EN is defined.
package dmem_line_responder_pkg;

  localparam int unsigned DMEM_LINE_WORDS = 4;
  localparam int unsigned DMEM_WORD_BITS  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StXfer,
    StDrain,
`ifdef DMEM_RESP_WAIT_EN
    StWait,
`endif
    StAck
  } type_dmem_resp_states_e;

endpackage

// File: rtl/dmem_line_responder.sv
// Serialises a data-cache line fill or write-back into single-word SRAM beats.
// Define DMEM_RESP_WAIT_EN to insert WAIT_CYCLES idle cycles before every beat.
module dmem_line_responder
  import dmem_line_responder_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = DMEM_LINE_WORDS,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 dcache2mem_req_i,
  input  logic                                 dcache2mem_wr_i,
  input  logic                                 dcache2mem_kill_i,
  input  logic [31:0]                          dcache2mem_addr_i,
  input  logic [DMEM_WORD_BITS*LINE_WORDS-1:0] dcache2mem_wdata_i,
  output logic                                 mem2dcache_ack_o,
  output logic [DMEM_WORD_BITS*LINE_WORDS-1:0] mem2dcache_rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [31:0]                          sram_addr_o,
  output logic [31:0]                          sram_wdata_o,
  input  logic [31:0]                          sram_rdata_i
);

  localparam int unsigned CntW     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned LineBits = DMEM_WORD_BITS * LINE_WORDS;
  localparam logic [CntW-1:0] LastBeat = CntW'(LINE_WORDS - 1);

  type_dmem_resp_states_e state_q, state_d;
  logic [CntW-1:0]     beat_q, beat_d;
  logic [27:0]         addr_q;
  logic                wr_q;
  logic [LineBits-1:0] wdata_q;
  logic [LineBits-1:0] line_q;
  logic                cap_valid_q;
  logic [CntW-1:0]     cap_idx_q;
  logic                accept;
  logic                strobe;
  logic                ack;
  logic [31:0]         beat_ext;
  logic [31:0]         wword;
  logic                unused_addr_bits;

`ifdef DMEM_RESP_WAIT_EN
  localparam int unsigned WaitW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam bit          UseWait  = (WAIT_CYCLES > 0);
  localparam logic [WaitW-1:0] LastWait = WaitW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  logic [WaitW-1:0] wait_q, wait_d;
`else
  localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
`endif

  assign unused_addr_bits = ^dcache2mem_addr_i[3:0];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    accept  = 1'b0;
    strobe  = 1'b0;
    ack     = 1'b0;
`ifdef DMEM_RESP_WAIT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      StIdle: begin
        if (dcache2mem_req_i) begin
          accept  = 1'b1;
          beat_d  = '0;
          state_d = StXfer;
`ifdef DMEM_RESP_WAIT_EN
          if (UseWait) begin
            state_d = StWait;
            wait_d  = '0;
          end
`endif
        end
      end
      StXfer: begin
        strobe = 1'b1;
        if (beat_q == LastBeat) begin
          state_d = wr_q ? StAck : StDrain;
        end else begin
          beat_d  = beat_q + CntW'(1);
          state_d = StXfer;
`ifdef DMEM_RESP_WAIT_EN
          if (UseWait) begin
            state_d = StWait;
            wait_d  = '0;
          end
`endif
        end
      end
`ifdef DMEM_RESP_WAIT_EN
      StWait: begin
        if (wait_q == LastWait) begin
          wait_d  = '0;
          state_d = StXfer;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
`endif
      // Last read word arrives this cycle and is captured by the pipeline below.
      StDrain: state_d = StAck;
      StAck: begin
        ack     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (dcache2mem_kill_i) begin
      state_d = StIdle;
      beat_d  = '0;
      accept  = 1'b0;
      strobe  = 1'b0;
      ack     = 1'b0;
`ifdef DMEM_RESP_WAIT_EN
      wait_d  = '0;
`endif
    end
  end

  always_comb begin
    wword = '0;
    for (int i = 0; i < int'(LINE_WORDS); i++) begin
      if (beat_q == CntW'(i)) wword = wdata_q[i*DMEM_WORD_BITS +: DMEM_WORD_BITS];
    end
  end

  assign beat_ext           = 32'(beat_q);
  assign mem2dcache_ack_o   = ack;
  assign mem2dcache_rdata_o = line_q;
  assign sram_req_o         = strobe;
  assign sram_we_o          = strobe & wr_q;
  assign sram_addr_o        = {addr_q, beat_ext[1:0], 2'b00};
  assign sram_wdata_o       = wword;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      line_q      <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
`ifdef DMEM_RESP_WAIT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
`ifdef DMEM_RESP_WAIT_EN
      wait_q      <= wait_d;
`endif
      // SRAM read data lags the strobe by one cycle; remember which word it is.
      cap_valid_q <= strobe & ~wr_q;
      cap_idx_q   <= beat_q;
      if (accept) begin
        addr_q  <= dcache2mem_addr_i[31:4];
        wr_q    <= dcache2mem_wr_i;
        wdata_q <= dcache2mem_wdata_i;
      end
      if (cap_valid_q) begin
        for (int i = 0; i < int'(LINE_WORDS); i++) begin
          if (cap_idx_q == CntW'(i)) line_q[i*DMEM_WORD_BITS +: DMEM_WORD_BITS] <= sram_rdata_i;
        end
      end
    end
  end

endmodule
